hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the MINI-RISC F/D/E/W pipeline. Generates the stall and flush controls for the FD, DE and EW registers, and the W-to-E operand forwarding selects. Sequences a post-reset pipeline purge and multi-cycle data-memory waits. Keeps saturating stall and flush counters for performance debug.

---
 rtl/pipeline_ctrl_pkg.sv | 21 ++
 rtl/hazard_ctrl_if.sv | 47 ++++
 rtl/hazard_ctrl_sat_counter.sv | 17 +
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_hazard_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the MINI-RISC pipeline control blocks.
// Holds the FSM state codes, the forwarding-select codes and the forwarding rule.
package pipeline_ctrl_pkg;

   localparam logic [1:0] STARTUP  = 2'b00;
   localparam logic [1:0] RUN      = 2'b01;
   localparam logic [1:0] MEM_WAIT = 2'b10;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_W   = 2'b01;

   localparam int STARTUP_CYCLES = 2;

   // A source operand takes the W result whenever W writes that register.
   function automatic logic [1:0] fwd_sel(input logic [1:0] write_mode,
                                          input logic [2:0] rd,
                                          input logic [2:0] rs);
      return ((write_mode != 2'b00) && (rd == rs)) ? FWD_W : FWD_REG;
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline status inputs and hazard-control outputs for hazard_ctrl.
// master is the pipeline side; slave is the controller side.
interface hazard_ctrl_if #(parameter int CNT_W = 16);

   logic [2:0]       rs1_D;
   logic [2:0]       rs2_D;
   logic             uses_rs1_D;
   logic             uses_rs2_D;
   logic [2:0]       rd_E;
   logic [1:0]       write_mode_E;
   logic             mem_read_E;
   logic [2:0]       rs1_E;
   logic [2:0]       rs2_E;
   logic [2:0]       rd_W;
   logic [1:0]       write_mode_W;
   logic             branch_taken_E;
   logic             mem_req_E;
   logic             mem_ready;

   logic             stall_F;
   logic             stall_D;
   logic             stall_E;
   logic             flush_F;
   logic             flush_D;
   logic             flush_E;
   logic [1:0]       fwd_a_E;
   logic [1:0]       fwd_b_E;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;
   logic             mem_timeout;

   modport master (
      output rs1_D, rs2_D, uses_rs1_D, uses_rs2_D, rd_E, write_mode_E, mem_read_E,
             rs1_E, rs2_E, rd_W, write_mode_W, branch_taken_E, mem_req_E, mem_ready,
      input  stall_F, stall_D, stall_E, flush_F, flush_D, flush_E, fwd_a_E, fwd_b_E,
             state, stall_count, flush_count, mem_timeout
   );

   modport slave (
      input  rs1_D, rs2_D, uses_rs1_D, uses_rs2_D, rd_E, write_mode_E, mem_read_E,
             rs1_E, rs2_E, rd_W, write_mode_W, branch_taken_E, mem_req_E, mem_ready,
      output stall_F, stall_D, stall_E, flush_F, flush_D, flush_E, fwd_a_E, fwd_b_E,
             state, stall_count, flush_count, mem_timeout
   );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Parameterised-width incrementer that sticks at all-ones instead of wrapping.
// Synchronous clear has priority over increment.
module sat_counter #(parameter int W = 16) (
   input  logic         clk,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear)
         count <= '0;
      else if (inc && (count != {W{1'b1}}))
         count <= count + W'(1);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward controller for the F/D/E/W pipeline, including the post-reset
// purge, data-memory wait sequencing and saturating performance counters.
module hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic         clk,
   input  logic         reset,
   hazard_ctrl_if.slave bus
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam int SU_W   = $clog2(STARTUP_CYCLES + 1);

   logic [1:0]        state_q;
   logic [1:0]        next_state;
   logic [1:0]        dec_state;
   logic [SU_W-1:0]   startup_cnt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              timeout_q;
   logic              load_use;
   logic              mem_stall;
   logic              branch_flush;
   logic              stall_f, stall_d, stall_e;
   logic              flush_f, flush_d, flush_e;

   // While reset is held the controls already look like STARTUP so the pipeline purges.
   assign dec_state = reset ? STARTUP : state_q;

   assign load_use = bus.mem_read_E && (bus.write_mode_E != 2'b00) &&
                     ((bus.uses_rs1_D && (bus.rs1_D == bus.rd_E)) ||
                      (bus.uses_rs2_D && (bus.rs2_D == bus.rd_E)));

   assign mem_stall = bus.mem_req_E && !bus.mem_ready;

   always_comb begin
      next_state   = state_q;
      branch_flush = 1'b0;
      stall_f      = 1'b0;
      stall_d      = 1'b0;
      stall_e      = 1'b0;
      flush_f      = 1'b0;
      flush_d      = 1'b0;
      flush_e      = 1'b0;
      case (dec_state)
         STARTUP: begin
            flush_f = 1'b1;
            flush_d = 1'b1;
            flush_e = 1'b1;
            if (startup_cnt == SU_W'(STARTUP_CYCLES - 1))
               next_state = RUN;
         end
         RUN: begin
            if (mem_stall) begin
               stall_f    = 1'b1;
               stall_d    = 1'b1;
               stall_e    = 1'b1;
               next_state = MEM_WAIT;
            end else if (bus.branch_taken_E) begin
               // The Decode instruction is killed, so a load-use on it is irrelevant.
               flush_f      = 1'b1;
               flush_d      = 1'b1;
               branch_flush = 1'b1;
            end else if (load_use) begin
               stall_f = 1'b1;
               flush_d = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (!bus.mem_ready) begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               stall_e = 1'b1;
            end else begin
               next_state = RUN;
            end
         end
         default: next_state = RUN;
      endcase
   end

   // The wait counter parks at MEM_TIMEOUT; the timeout flag is sticky until reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= STARTUP;
         startup_cnt <= '0;
         wait_cnt    <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q <= next_state;
         if (state_q == STARTUP)
            startup_cnt <= startup_cnt + SU_W'(1);
         if (state_q == MEM_WAIT) begin
            if (bus.mem_ready) begin
               wait_cnt <= '0;
            end else begin
               if (wait_cnt != WAIT_W'(MEM_TIMEOUT))
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               if (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1))
                  timeout_q <= 1'b1;
            end
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clear (reset),
      .inc   (stall_f | stall_d | stall_e),
      .count (bus.stall_count)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .clear (reset),
      .inc   (branch_flush),
      .count (bus.flush_count)
   );

   assign bus.stall_F     = stall_f;
   assign bus.stall_D     = stall_d;
   assign bus.stall_E     = stall_e;
   assign bus.flush_F     = flush_f;
   assign bus.flush_D     = flush_d;
   assign bus.flush_E     = flush_e;
   assign bus.fwd_a_E     = fwd_sel(bus.write_mode_W, bus.rd_W, bus.rs1_E);
   assign bus.fwd_b_E     = fwd_sel(bus.write_mode_W, bus.rd_W, bus.rs2_E);
   assign bus.state       = state_q;
   assign bus.mem_timeout = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a per-cycle reference model pushes expected
// outputs into a queue and an independent monitor pops and compares them.
module tb_hazard_ctrl;

   localparam int CNT_W       = 3;
   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   typedef struct {
      logic       rst;
      logic [2:0] rs1_D, rs2_D;
      logic       u1, u2;
      logic [2:0] rd_E;
      logic [1:0] wm_E;
      logic       mr_E;
      logic [2:0] rs1_E, rs2_E, rd_W;
      logic [1:0] wm_W;
      logic       br, mreq, mrdy;
   } stim_t;

   typedef struct packed {
      logic [1:0]       state;
      logic [5:0]       ctrl;
      logic [1:0]       fa;
      logic [1:0]       fb;
      logic [CNT_W-1:0] sc;
      logic [CNT_W-1:0] fc;
      logic             to;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   int   cycle    = 0;
   exp_t exp_q[$];

   // Model: phase 0 = purge, 1 = running, 2 = waiting on memory.
   int m_phase, m_startup_left, m_waits, m_stalls, m_flushes;
   bit m_timeout;

   hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

   hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic stim_t idle();
      stim_t s;
      s = '{rst: 1'b0, rs1_D: 3'd0, rs2_D: 3'd0, u1: 1'b0, u2: 1'b0, rd_E: 3'd0,
            wm_E: 2'd0, mr_E: 1'b0, rs1_E: 3'd0, rs2_E: 3'd0, rd_W: 3'd0,
            wm_W: 2'd0, br: 1'b0, mreq: 1'b0, mrdy: 1'b0};
      return s;
   endfunction

   function automatic logic [1:0] phase_code(input int p);
      case (p)
         0:       return 2'b00;
         1:       return 2'b01;
         default: return 2'b10;
      endcase
   endfunction

   task automatic drive(input stim_t s);
      reset              = s.rst;
      bus.rs1_D          = s.rs1_D;
      bus.rs2_D          = s.rs2_D;
      bus.uses_rs1_D     = s.u1;
      bus.uses_rs2_D     = s.u2;
      bus.rd_E           = s.rd_E;
      bus.write_mode_E   = s.wm_E;
      bus.mem_read_E     = s.mr_E;
      bus.rs1_E          = s.rs1_E;
      bus.rs2_E          = s.rs2_E;
      bus.rd_W           = s.rd_W;
      bus.write_mode_W   = s.wm_W;
      bus.branch_taken_E = s.br;
      bus.mem_req_E      = s.mreq;
      bus.mem_ready      = s.mrdy;
   endtask

   task automatic model_reset();
      m_phase        = 0;
      m_startup_left = 2;
      m_waits        = 0;
      m_stalls       = 0;
      m_flushes      = 0;
      m_timeout      = 1'b0;
   endtask

   // Drives one cycle of stimulus and queues the response the model predicts for it.
   task automatic apply_stimulus(input stim_t s);
      exp_t e;
      bit   sf, sd, se, ff, fd, fe, lu;
      @(negedge clk);
      #1;
      drive(s);
      cycle++;
      {sf, sd, se, ff, fd, fe} = 6'b0;
      e.state = phase_code(m_phase);
      e.sc    = CNT_W'(m_stalls);
      e.fc    = CNT_W'(m_flushes);
      e.to    = m_timeout;
      e.fa    = (s.wm_W != 0 && s.rd_W == s.rs1_E) ? 2'b01 : 2'b00;
      e.fb    = (s.wm_W != 0 && s.rd_W == s.rs2_E) ? 2'b01 : 2'b00;
      lu = s.mr_E && (s.wm_E != 0) &&
           ((s.u1 && s.rs1_D == s.rd_E) || (s.u2 && s.rs2_D == s.rd_E));
      if (s.rst) begin
         {ff, fd, fe} = 3'b111;
         model_reset();
      end else begin
         if (m_phase == 0) begin
            {ff, fd, fe} = 3'b111;
            m_startup_left--;
            if (m_startup_left == 0) m_phase = 1;
         end else if (m_phase == 1) begin
            if (s.mreq && !s.mrdy) begin
               {sf, sd, se} = 3'b111;
               m_phase = 2;
            end else if (s.br) begin
               {ff, fd} = 2'b11;
               m_flushes = (m_flushes < CNT_MAX) ? m_flushes + 1 : CNT_MAX;
            end else if (lu) begin
               sf = 1'b1;
               fd = 1'b1;
            end
         end else begin
            if (!s.mrdy) begin
               {sf, sd, se} = 3'b111;
               m_waits++;
               if (m_waits >= MEM_TIMEOUT) m_timeout = 1'b1;
            end else begin
               m_phase = 1;
               m_waits = 0;
            end
         end
         if (sf || sd || se)
            m_stalls = (m_stalls < CNT_MAX) ? m_stalls + 1 : CNT_MAX;
      end
      e.ctrl = {sf, sd, se, ff, fd, fe};
      exp_q.push_back(e);
   endtask

   task automatic compare(input string name, input logic [7:0] act, input logic [7:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", name, cycle, act, want);
      end
   endtask

   task automatic check_output(input exp_t e);
      compare("state", {6'b0, bus.state}, {6'b0, e.state});
      compare("stall_flush",
              {2'b0, bus.stall_F, bus.stall_D, bus.stall_E, bus.flush_F, bus.flush_D, bus.flush_E},
              {2'b0, e.ctrl});
      compare("fwd", {4'b0, bus.fwd_a_E, bus.fwd_b_E}, {4'b0, e.fa, e.fb});
      compare("stall_count", 8'(bus.stall_count), 8'(e.sc));
      compare("flush_count", 8'(bus.flush_count), 8'(e.fc));
      compare("mem_timeout", {7'b0, bus.mem_timeout}, {7'b0, e.to});
   endtask

   // Monitor: outputs are combinational each cycle, so every cycle is a response.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output(e);
         end
      end
   end

   initial begin
      stim_t s;
      int    bias;
      drive(idle());
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      model_reset();

      // Purge after reset, then settle in RUN.
      for (int i = 0; i < 4; i++) apply_stimulus(idle());

      // Load-use bubble, then the load forwarded from W.
      s = idle(); s.rd_E = 3; s.mr_E = 1; s.wm_E = 2'b01; s.rs2_D = 3; s.u2 = 1;
      apply_stimulus(s);
      s = idle(); s.rd_W = 3; s.wm_W = 2'b01; s.rs2_E = 3;
      apply_stimulus(s);

      // Taken branch masks a simultaneous load-use.
      s = idle(); s.br = 1; s.rd_E = 5; s.mr_E = 1; s.wm_E = 2'b10; s.rs1_D = 5; s.u1 = 1;
      apply_stimulus(s);
      apply_stimulus(idle());

      // Memory wait: three not-ready waits then ready; branch ignored while waiting.
      s = idle(); s.mreq = 1; apply_stimulus(s);
      s = idle(); s.br = 1;
      for (int i = 0; i < 3; i++) apply_stimulus(s);
      s = idle(); s.mrdy = 1; apply_stimulus(s);
      apply_stimulus(idle());

      // Same-cycle ready causes no stall.
      s = idle(); s.mreq = 1; s.mrdy = 1; apply_stimulus(s);

      // Long wait: timeout and counter saturation, flag held through ready, cleared by reset.
      s = idle(); s.mreq = 1; apply_stimulus(s);
      for (int i = 0; i < 10; i++) apply_stimulus(idle());
      s = idle(); s.mrdy = 1; apply_stimulus(s);
      apply_stimulus(idle());
      s = idle(); s.rst = 1; apply_stimulus(s);
      apply_stimulus(idle());

      // Reset asserted in the middle of a wait.
      for (int i = 0; i < 3; i++) apply_stimulus(idle());
      s = idle(); s.mreq = 1; apply_stimulus(s);
      apply_stimulus(idle());
      s = idle(); s.rst = 1; apply_stimulus(s);

      // Randomized traffic with a drifting memory-ready bias.
      bias = 50;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 49) == 0) bias = $urandom_range(5, 95);
         s.rst   = ($urandom_range(0, 79) == 0);
         s.rs1_D = 3'($urandom_range(0, 3));
         s.rs2_D = 3'($urandom_range(0, 3));
         s.u1    = 1'($urandom_range(0, 1));
         s.u2    = 1'($urandom_range(0, 1));
         s.rd_E  = 3'($urandom_range(0, 3));
         s.wm_E  = 2'($urandom_range(0, 3));
         s.mr_E  = 1'($urandom_range(0, 1));
         s.rs1_E = 3'($urandom_range(0, 3));
         s.rs2_E = 3'($urandom_range(0, 3));
         s.rd_W  = 3'($urandom_range(0, 3));
         s.wm_W  = 2'($urandom_range(0, 3));
         s.br    = ($urandom_range(0, 5) == 0);
         s.mreq  = ($urandom_range(0, 4) == 0);
         s.mrdy  = ($urandom_range(0, 99) < bias);
         apply_stimulus(s);
      end

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
